// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage rv32i core: per-stage advance/hold/squash
// decisions from memory waits, load-use interlocks and EX redirects, plus saturating perf counters.
module hazard_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       ID_RS1,
   input  logic [4:0]       ID_RS2,
   input  logic             ID_uses_rs1,
   input  logic             ID_uses_rs2,
   input  logic             EX_MemRead,
   input  logic [4:0]       EX_RD,
   input  logic             EX_redirect,
   input  logic             imem_read,
   input  logic             imem_resp,
   input  logic             dmem_req,
   input  logic             dmem_resp,
   output logic             pc_en,
   output logic             IF_ID_en,
   output logic             ID_EX_en,
   output logic             EX_MEM_en,
   output logic             MEM_WB_en,
   output logic             IF_ID_flush,
   output logic             ID_EX_flush,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   typedef enum logic [0:0] {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_t;

   state_t state;
   logic   imem_done;
   logic   dmem_done;

   logic   imem_ok;
   logic   dmem_ok;
   logic   mem_ready;
   logic   mem_stall;
   logic   rs1_hit;
   logic   rs2_hit;
   logic   load_use;
   logic   redirect_act;
   logic   load_use_act;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
      logic [CNT_W-1:0] result;
      if (&value) begin
         result = value;
      end else begin
         result = value + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      return result;
   endfunction

   // A port is satisfied if idle, answering now, or already answered while waiting.
   always_comb begin
      imem_ok   = !imem_read || imem_resp || imem_done;
      dmem_ok   = !dmem_req  || dmem_resp || dmem_done;
      mem_ready = imem_ok && dmem_ok;
      mem_stall = !mem_ready;
   end

   always_comb begin
      rs1_hit  = ID_uses_rs1 && (ID_RS1 == EX_RD);
      rs2_hit  = ID_uses_rs2 && (ID_RS2 == EX_RD);
      load_use = EX_MemRead && (EX_RD != 5'd0) && (rs1_hit || rs2_hit);
   end

   // Memory stall dominates; a redirect squashes ID so it masks any load-use.
   always_comb begin
      redirect_act = 1'b0;
      load_use_act = 1'b0;
      if (rst) begin
         redirect_act = 1'b0;
         load_use_act = 1'b0;
      end else if (mem_stall) begin
         redirect_act = 1'b0;
         load_use_act = 1'b0;
      end else if (EX_redirect) begin
         redirect_act = 1'b1;
      end else if (load_use) begin
         load_use_act = 1'b1;
      end else begin
         redirect_act = 1'b0;
         load_use_act = 1'b0;
      end
   end

   always_comb begin
      pc_en       = 1'b1;
      IF_ID_en    = 1'b1;
      ID_EX_en    = 1'b1;
      EX_MEM_en   = 1'b1;
      MEM_WB_en   = 1'b1;
      IF_ID_flush = 1'b0;
      ID_EX_flush = 1'b0;
      if (rst) begin
         pc_en       = 1'b0;
         IF_ID_en    = 1'b0;
         ID_EX_en    = 1'b0;
         EX_MEM_en   = 1'b0;
         MEM_WB_en   = 1'b0;
         IF_ID_flush = 1'b1;
         ID_EX_flush = 1'b1;
      end else if (mem_stall) begin
         pc_en     = 1'b0;
         IF_ID_en  = 1'b0;
         ID_EX_en  = 1'b0;
         EX_MEM_en = 1'b0;
         MEM_WB_en = 1'b0;
      end else if (redirect_act) begin
         IF_ID_flush = 1'b1;
         ID_EX_flush = 1'b1;
      end else if (load_use_act) begin
         pc_en       = 1'b0;
         IF_ID_en    = 1'b0;
         ID_EX_flush = 1'b1;
      end else begin
         pc_en       = 1'b1;
         IF_ID_en    = 1'b1;
      end
   end

   // Sticky flags keep early responses so the advance can happen on the last one.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= RUN;
         imem_done <= 1'b0;
         dmem_done <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (!mem_ready) begin
                  state     <= MEM_WAIT;
                  imem_done <= imem_resp;
                  dmem_done <= dmem_resp;
               end else begin
                  state     <= RUN;
                  imem_done <= 1'b0;
                  dmem_done <= 1'b0;
               end
            end
            MEM_WAIT: begin
               if (mem_ready) begin
                  state     <= RUN;
                  imem_done <= 1'b0;
                  dmem_done <= 1'b0;
               end else begin
                  state     <= MEM_WAIT;
                  imem_done <= imem_done || imem_resp;
                  dmem_done <= dmem_done || dmem_resp;
               end
            end
            default: begin
               state     <= RUN;
               imem_done <= 1'b0;
               dmem_done <= 1'b0;
            end
         endcase
      end
   end

   // Performance counters saturate at all-ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_count <= {CNT_W{1'b0}};
         flush_count <= {CNT_W{1'b0}};
      end else begin
         if (mem_stall || load_use_act) begin
            stall_count <= sat_inc(stall_count);
         end else begin
            stall_count <= stall_count;
         end
         if (redirect_act) begin
            flush_count <= sat_inc(flush_count);
         end else begin
            flush_count <= flush_count;
         end
      end
   end

endmodule
